// File: rtl/writeback_if.sv
// writeback_if: issue-side handshake, memory return and register-file write port of the writeback stage.
interface writeback_if #(
  parameter int REG_DATA_WIDTH = 16,
  parameter int REG_ADDR_WIDTH = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      wb_src;
  logic                      reg_write;
  logic [REG_ADDR_WIDTH-1:0] dest_reg;
  logic [REG_DATA_WIDTH-1:0] alu_result;
  logic                      mem_valid;
  logic [REG_DATA_WIDTH-1:0] mem_data;
  logic                      wr_en;
  logic [REG_ADDR_WIDTH-1:0] wr_addr;
  logic [REG_DATA_WIDTH-1:0] wr_data;
  logic                      stall;
  logic                      err;
  modport master (
    output in_valid, wb_src, reg_write, dest_reg, alu_result, mem_valid, mem_data,
    input  in_ready, wr_en, wr_addr, wr_data, stall, err
  );
  modport slave (
    input  in_valid, wb_src, reg_write, dest_reg, alu_result, mem_valid, mem_data,
    output in_ready, wr_en, wr_addr, wr_data, stall, err
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: routes ALU results and multi-cycle loads to the register file write port, aborting loads on timeout.
module writeback_unit #(
  parameter int REG_DATA_WIDTH = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int MEM_TIMEOUT    = 15
) (
  input logic        clk,
  input logic        rst,
  writeback_if.slave bus
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t                    state;
  logic [7:0]                cnt;
  logic [REG_ADDR_WIDTH-1:0] ld_dest;
  logic                      ld_write;
  logic                      accept;
  logic                      alu_wr;
  logic                      ld_wr;
  assign bus.in_ready = state == IDLE;
  assign bus.stall    = state != IDLE;
  assign accept       = bus.in_valid && bus.in_ready;
  assign alu_wr       = bus.reg_write && |bus.dest_reg;
  assign ld_wr        = ld_write && |ld_dest;
  // wr_addr/wr_data only move on an actual write so they hold otherwise
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ld_dest     <= '0;
      ld_write    <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.err     <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      bus.err   <= 1'b0;
      if (state == IDLE) begin
        if (accept && !bus.wb_src) begin
          bus.wr_en <= alu_wr;
          if (alu_wr) begin
            bus.wr_addr <= bus.dest_reg;
            bus.wr_data <= bus.alu_result;
          end
        end else if (accept) begin
          ld_dest  <= bus.dest_reg;
          ld_write <= bus.reg_write;
          cnt      <= '0;
          state    <= WAIT_MEM;
        end
      end else if (bus.mem_valid) begin
        bus.wr_en <= ld_wr;
        if (ld_wr) begin
          bus.wr_addr <= ld_dest;
          bus.wr_data <= bus.mem_data;
        end
        state <= IDLE;
      end else if (cnt == 8'(MEM_TIMEOUT - 1)) begin
        bus.err <= 1'b1;
        state   <= IDLE;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and random stimulus against a transaction-level model of the writeback stage.
module tb_writeback_unit;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;
  writeback_if #(.REG_DATA_WIDTH(16), .REG_ADDR_WIDTH(4)) bus ();
  writeback_unit #(.REG_DATA_WIDTH(16), .REG_ADDR_WIDTH(4), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  // model: an outstanding load is just "who, whether, and how long it has waited"
  bit          pend;
  int          waited;
  logic [3:0]  pend_dest;
  bit          pend_rw;
  bit          e_en, e_err;
  logic [3:0]  e_addr;
  logic [15:0] e_data;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic check_outputs();
    chk("wr_en", 16'(bus.wr_en), 16'(e_en));
    chk("err", 16'(bus.err), 16'(e_err));
    chk("in_ready", 16'(bus.in_ready), 16'(!pend));
    chk("stall", 16'(bus.stall), 16'(pend));
    chk("excl", 16'(bus.wr_en && bus.err), 16'd0);
    if (e_en) begin
      chk("wr_addr", 16'(bus.wr_addr), 16'(e_addr));
      chk("wr_data", bus.wr_data, e_data);
    end
  endtask
  task automatic cycle(input bit v, input bit src, input bit rw, input logic [3:0] d,
                       input logic [15:0] a, input bit mv, input logic [15:0] md);
    bus.in_valid = v; bus.wb_src = src; bus.reg_write = rw; bus.dest_reg = d;
    bus.alu_result = a; bus.mem_valid = mv; bus.mem_data = md;
    e_en = 0; e_err = 0;
    if (pend) begin
      waited++;
      if (mv) begin
        pend = 0;
        if (pend_rw && pend_dest != 0) begin e_en = 1; e_addr = pend_dest; e_data = md; end
      end else if (waited == TO) begin
        pend = 0; e_err = 1;
      end
    end else if (v && !src) begin
      if (rw && d != 0) begin e_en = 1; e_addr = d; e_data = a; end
    end else if (v) begin
      pend = 1; waited = 0; pend_dest = d; pend_rw = rw;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    bus.in_valid = 0; bus.wb_src = 0; bus.reg_write = 0; bus.dest_reg = 0;
    bus.alu_result = 0; bus.mem_valid = 0; bus.mem_data = 0;
    pend = 0; waited = 0; pend_dest = 0; pend_rw = 0; e_en = 0; e_err = 0; e_addr = 0; e_data = 0;
    #1;
    check_outputs();
    chk("rst_addr", 16'(bus.wr_addr), 16'd0);
    chk("rst_data", bus.wr_data, 16'd0);
    @(negedge clk); @(negedge clk);
    rst = 1;
    idle(1);
    // reset in the middle of a load
    cycle(1, 1, 1, 4'd3, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    pend = 0; e_en = 0; e_err = 0;
    #1;
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1;
    idle(2);
    // back-to-back ALU ops, last one targets r0
    cycle(1, 0, 1, 4'd1, 16'h1234, 0, 0);
    cycle(1, 0, 1, 4'd2, 16'hFFFF, 0, 0);
    cycle(1, 0, 1, 4'd0, 16'h5555, 0, 0);
    idle(1);
    // load latency
    cycle(1, 1, 1, 4'd5, 0, 0, 0);
    idle(3);
    cycle(0, 0, 0, 0, 0, 1, 16'hBEEF);
    idle(1);
    // ALU op held during a load wait
    cycle(1, 1, 1, 4'd7, 0, 0, 0);
    cycle(1, 0, 1, 4'd9, 16'hA5A5, 0, 0);
    cycle(1, 0, 1, 4'd9, 16'hA5A5, 0, 0);
    cycle(1, 0, 1, 4'd9, 16'hA5A5, 1, 16'hC0DE);
    cycle(1, 0, 1, 4'd9, 16'hA5A5, 0, 0);
    idle(1);
    // data on the last legal wait cycle, then a full timeout
    cycle(1, 1, 1, 4'd4, 0, 0, 0);
    idle(TO - 1);
    cycle(0, 0, 0, 0, 0, 1, 16'h7E57);
    cycle(1, 1, 1, 4'd4, 0, 0, 0);
    idle(TO);
    idle(1);
    // stray memory data and a non-writing load
    cycle(0, 0, 0, 0, 0, 1, 16'hDEAD);
    cycle(1, 1, 0, 4'd6, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 16'h1111);
    idle(1);
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
            4'($urandom), 16'($urandom), 1'($urandom_range(0, 7) == 0), 16'($urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
